shift_register: RTL and testbench
=================================

Name: shift_register

Overview:
- Parameterised serial-in/parallel-out shift register with serial-out tap and clock enable.
- One serial bit per enabled clock enters at the LSB; the full register is exposed on Q.
- Used as a generic deserialiser / delay line in datapath glue logic.
- Single clock domain; asynchronous active-low reset.

Parameters:
- WIDTH, 4, number of register stages (width of Q); legal range 2..64.
- RESET_VALUE, 0, value loaded into Q on reset, WIDTH bits wide.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low (0 = reset asserted).
- en  input  1  shift enable; Q holds when 0.
- Din  input  1  serial data in, captured into Q[0].
- Q  output  WIDTH  parallel register contents, registered.
- Dout  output  1  serial out, equals Q[WIDTH-1] (combinational tap of the register, no extra stage).

Behaviour:
- Reset: rst=0 forces Q=RESET_VALUE immediately, independent of clk. Dout then follows as RESET_VALUE[WIDTH-1].
- Reset is held for as long as rst=0; all clock edges during reset are ignored.
- Release: deassertion of rst is not synchronised inside the block. The first shift occurs on the first rising clk edge with rst=1 and en=1.
- Shift: on rising clk with rst=1 and en=1, Q <= {Q[WIDTH-2:0], Din}.
- Hold: with en=0, Q is unchanged.
- Latency: Din appears on Q[0] one enabled edge after capture and on Dout WIDTH enabled edges after capture.
- Bits shifted out of Q[WIDTH-1] are discarded. There is no wrap-around and no saturation.
- Din and en are sampled only at the rising edge. Changes between edges have no effect.
- Reset asserted mid-stream discards all stored bits; shifting resumes from RESET_VALUE.
- If rst asserts coincident with a clock edge, reset wins.
- X on Din while en=1 propagates into Q; X on en is a protocol violation. The verification assertion flags it when rst=1.

Optional Feature:
- Macro: SHIFT_REGISTER_LOAD_EN.
- When defined:
  - Adds input load (1 bit) and input Pin (WIDTH bits).
  - On a rising edge with rst=1 and load=1, Q <= Pin, regardless of en.
  - load has priority over shift.
  - Reset still overrides everything.
- When undefined:
  - The load and Pin ports do not exist.
  - Behaviour is exactly the base shift/hold behaviour above.

Decomposition:
- Package shift_register_pkg holds:
  - default WIDTH constant (4);
  - a function computing the next Q from current Q, Din, en (and load/Pin when enabled).
  The bench reuses this function as its reference model.
- No sub-module is needed. A single always block with async reset plus a continuous Dout assignment is sufficient.
- Bench-side scoreboard/model class is separate from RTL.

Test Plan:
- Async reset: Q=1010 mid-cycle, drive rst=0 between edges -> Q=0000 immediately without waiting for clk; Dout=0.
- Serial fill, WIDTH=4, en=1, from Q=0000: Din 1,0,1,1 on four edges -> Q=0001, 0010, 0101, 1011; Dout=1 after the fourth edge.
- Hold: Q=1011, en=0 for 3 edges with Din toggling -> Q stays 1011. Then en=1, Din=0 -> Q=0110.
- Overflow/discard: from Q=1111, shift Din=0 four times -> Q=1110, 1100, 1000, 0000. Dout sequence is 1,1,1,0 (sampled after each edge).
- Reset release timing: release rst 3 ns before a clk edge with en=1, Din=1 -> that edge shifts (Q=0001); Din=1 on subsequent edges -> 0011, 0111, 1111.
- With SHIFT_REGISTER_LOAD_EN: load=1, Pin=1001, en=1, Din=0 on one edge -> Q=1001 (load wins); next edge load=0, Din=1 -> Q=0011.

Source files
------------

// File: rtl/shift_register_pkg.sv
// Shared types and next-state helper for shift_register.
// The per-bit helper gains load/Pin inputs when SHIFT_REGISTER_LOAD_EN is defined.
package shift_register_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Next value of one register stage; load beats shift, shift beats hold.
  function automatic logic next_bit(
    input logic shift_in,
    input logic cur,
    input logic en
`ifdef SHIFT_REGISTER_LOAD_EN
    ,
    input logic load,
    input logic pin_bit
`endif
  );
    logic nb;
`ifdef SHIFT_REGISTER_LOAD_EN
    if (load) begin
      nb = pin_bit;
    end else if (en) begin
      nb = shift_in;
    end else begin
      nb = cur;
    end
`else
    if (en) begin
      nb = shift_in;
    end else begin
      nb = cur;
    end
`endif
    return nb;
  endfunction

endpackage

// File: rtl/shift_register_chk.sv
// Protocol checker for shift_register: en must be known whenever reset is released.
module shift_register_chk (
  input logic clk,
  input logic rst,
  input logic en
);

  // Flag an unknown enable outside reset.
  en_known_a: assert property (@(posedge clk) disable iff (!rst) !$isunknown(en))
    else $error("shift_register_chk: en is X/Z while out of reset");

endmodule

// File: rtl/shift_register.sv
// Serial-in/parallel-out shift register with serial-out tap and clock enable.
// Define SHIFT_REGISTER_LOAD_EN to add a synchronous parallel load (load, Pin).
module shift_register
  import shift_register_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             Din,
`ifdef SHIFT_REGISTER_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] Pin,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             Dout
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] shift_in_s;
  logic [WIDTH-1:0] next_s;

  assign shift_in_s = {q_r[WIDTH-2:0], Din};

  // Per-stage next-state selection.
  always_comb begin
    next_s = q_r;
    for (int i = 0; i < WIDTH; i++) begin
`ifdef SHIFT_REGISTER_LOAD_EN
      next_s[i] = next_bit(shift_in_s[i], q_r[i], en, load, Pin[i]);
`else
      next_s[i] = next_bit(shift_in_s[i], q_r[i], en);
`endif
    end
  end

  // Register state; reset is asynchronous and overrides any clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r <= RESET_VALUE;
    end else begin
      q_r <= next_s;
    end
  end

  assign Q    = q_r;
  assign Dout = q_r[WIDTH-1];

endmodule

// File: tb/tb_shift_register.sv
// Directed plus random scoreboard bench for shift_register (WIDTH=4).
// Exercises the parallel load path when SHIFT_REGISTER_LOAD_EN is defined.
module tb_shift_register;
  import shift_register_pkg::*;

  localparam int W = 4;

  logic         clk  = 1'b0;
  logic         rst  = 1'b0;
  logic         en   = 1'b0;
  logic         Din  = 1'b0;
`ifdef SHIFT_REGISTER_LOAD_EN
  logic         load = 1'b0;
  logic [W-1:0] Pin  = '0;
`endif
  logic [W-1:0] Q;
  logic         Dout;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_q;
  int           checks_total = 0;
  int           checks_pass  = 0;

  always #5 clk = ~clk;

  shift_register #(.WIDTH(W), .RESET_VALUE(4'b0000)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .Din  (Din),
`ifdef SHIFT_REGISTER_LOAD_EN
    .load (load),
    .Pin  (Pin),
`endif
    .Q    (Q),
    .Dout (Dout)
  );

  shift_register_chk u_chk (.clk(clk), .rst(rst), .en(en));

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks_total++;
    assert (obs === expv) checks_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, expv);
  endtask

  task automatic pop_check(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      checks_total++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, Q, e);
      check({tag, "_dout"}, {3'b000, Dout}, {3'b000, e[W-1]});
    end
  endtask

  // Drive one clock of stimulus, record the expected Q, compare after the edge.
  task automatic step(input logic e, input logic d, input logic [W-1:0] expv, input string tag);
    en  = e;
    Din = d;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  task automatic rand_step();
    logic e;
    logic d;
    logic [W-1:0] shin;
    logic [W-1:0] nq;
    e    = 1'($urandom_range(0, 1));
    d    = 1'($urandom_range(0, 1));
    shin = {model_q[W-2:0], d};
    for (int i = 0; i < W; i++) begin
`ifdef SHIFT_REGISTER_LOAD_EN
      nq[i] = next_bit(shin[i], model_q[i], e, 1'b0, 1'b0);
`else
      nq[i] = next_bit(shin[i], model_q[i], e);
`endif
    end
    model_q = nq;
    step(e, d, nq, "random");
  endtask

  initial begin
    #1;
    check("reset_q", Q, 4'b0000);
    check("reset_dout", {3'b000, Dout}, 4'b0000);
    step(1'b1, 1'b1, 4'b0000, "reset_held0");
    step(1'b1, 1'b1, 4'b0000, "reset_held1");

    // Release 3 ns before an edge with en=1, Din=1: that edge shifts.
    #6;
    rst = 1'b1;
    en  = 1'b1;
    Din = 1'b1;
    exp_q.push_back(4'b0001);
    @(posedge clk);
    #1;
    pop_check("release_edge");
    step(1'b1, 1'b1, 4'b0011, "release1");
    step(1'b1, 1'b1, 4'b0111, "release2");
    step(1'b1, 1'b1, 4'b1111, "release3");

    step(1'b1, 1'b0, 4'b1110, "discard0");
    step(1'b1, 1'b0, 4'b1100, "discard1");
    step(1'b1, 1'b0, 4'b1000, "discard2");
    step(1'b1, 1'b0, 4'b0000, "discard3");

    step(1'b1, 1'b1, 4'b0001, "fill0");
    step(1'b1, 1'b0, 4'b0010, "fill1");
    step(1'b1, 1'b1, 4'b0101, "fill2");
    step(1'b1, 1'b1, 4'b1011, "fill3");

    step(1'b0, 1'b0, 4'b1011, "hold0");
    step(1'b0, 1'b1, 4'b1011, "hold1");
    step(1'b0, 1'b0, 4'b1011, "hold2");
    step(1'b1, 1'b0, 4'b0110, "hold_resume");

    step(1'b1, 1'b1, 4'b1101, "pre_reset0");
    step(1'b1, 1'b0, 4'b1010, "pre_reset1");

    // Assert reset between edges: Q must clear without a clock edge.
    #3;
    rst = 1'b0;
    #1;
    check("async_reset_q", Q, 4'b0000);
    check("async_reset_dout", {3'b000, Dout}, 4'b0000);
    step(1'b1, 1'b1, 4'b0000, "reset_held2");

    en  = 1'b0;
    rst = 1'b1;
    model_q = 4'b0000;
`ifdef SHIFT_REGISTER_LOAD_EN
    load = 1'b1;
    Pin  = 4'b1001;
    step(1'b1, 1'b0, 4'b1001, "load_wins");
    load = 1'b0;
    step(1'b1, 1'b1, 4'b0011, "after_load");
    load = 1'b1;
    Pin  = 4'b0110;
    step(1'b0, 1'b1, 4'b0110, "load_no_en");
    load = 1'b0;
    model_q = 4'b0110;
`endif

    for (int k = 0; k < 24; k++) begin
      rand_step();
    end

    check("scoreboard_empty", 4'(exp_q.size()), 4'b0000);
    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule
